logic_op_decoder: RTL and testbench



---
 rtl/logic_dec_pkg.sv | 62 ++++++
 rtl/logic_dec_table.sv | 49 ++++
 rtl/logic_op_decoder.sv | 147 ++++++++++++++
 tb/tb_logic_op_decoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_dec_pkg.sv
// Shared types and constants for the MIPS logical-instruction decoder.
// Decoded entries carry the raw imm16; the top zero-extends it to XLEN.
package logic_dec_pkg;

    localparam logic [1:0] LU_AND = 2'b00;
    localparam logic [1:0] LU_OR  = 2'b01;
    localparam logic [1:0] LU_NOR = 2'b10;
    localparam logic [1:0] LU_XOR = 2'b11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef struct packed {
        logic [1:0]  control;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        use_imm;
        logic [15:0] imm;
        logic        illegal;
    } dec_entry_t;

    localparam dec_entry_t DEC_ILLEGAL = '{
        control: LU_AND, rs: 5'd0, rt: 5'd0, dest: 5'd0,
        use_imm: 1'b0, imm: 16'd0, illegal: 1'b1
    };

    function automatic dec_entry_t r_type_entry(input logic [1:0] ctl, input logic [4:0] rs,
                                                input logic [4:0] rt, input logic [4:0] rd);
        dec_entry_t e;
        e.control = ctl;
        e.rs      = rs;
        e.rt      = rt;
        e.dest    = rd;
        e.use_imm = 1'b0;
        e.imm     = 16'd0;
        e.illegal = 1'b0;
        return e;
    endfunction

    // I-type ops write rt and have no second register source.
    function automatic dec_entry_t i_type_entry(input logic [1:0] ctl, input logic [4:0] rs,
                                                input logic [4:0] rt, input logic [15:0] imm);
        dec_entry_t e;
        e.control = ctl;
        e.rs      = rs;
        e.rt      = 5'd0;
        e.dest    = rt;
        e.use_imm = 1'b1;
        e.imm     = imm;
        e.illegal = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/logic_dec_table.sv
// Pure combinational instruction-word to decoded-entry table.
module logic_dec_table
    import logic_dec_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_entry_t  o_entry
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    assign w_opcode = i_instr[31:26];
    assign w_rs     = i_instr[25:21];
    assign w_rt     = i_instr[20:16];
    assign w_rd     = i_instr[15:11];
    assign w_shamt  = i_instr[10:6];
    assign w_funct  = i_instr[5:0];
    assign w_imm    = i_instr[15:0];

    // Opcode/funct lookup; anything unrecognised collapses to the illegal entry.
    always_comb begin
        o_entry = DEC_ILLEGAL;
        case (w_opcode)
            OP_SPECIAL: begin
                if (w_shamt == 5'd0) begin
                    case (w_funct)
                        FN_AND:  o_entry = r_type_entry(LU_AND, w_rs, w_rt, w_rd);
                        FN_OR:   o_entry = r_type_entry(LU_OR,  w_rs, w_rt, w_rd);
                        FN_NOR:  o_entry = r_type_entry(LU_NOR, w_rs, w_rt, w_rd);
                        FN_XOR:  o_entry = r_type_entry(LU_XOR, w_rs, w_rt, w_rd);
                        default: o_entry = DEC_ILLEGAL;
                    endcase
                end else begin
                    o_entry = DEC_ILLEGAL;
                end
            end
            OP_ANDI: o_entry = i_type_entry(LU_AND, w_rs, w_rt, w_imm);
            OP_ORI:  o_entry = i_type_entry(LU_OR,  w_rs, w_rt, w_imm);
            OP_XORI: o_entry = i_type_entry(LU_XOR, w_rs, w_rt, w_imm);
            default: o_entry = DEC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/logic_op_decoder.sv
// MIPS logical-op decoder with a 2-entry registered output buffer.
// Define LOGIC_DEC_TRAP_EN to add the sticky illegal-instruction trap.
module logic_op_decoder
    import logic_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_control,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_dest,
    output logic            out_use_imm,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
`ifdef LOGIC_DEC_TRAP_EN
    ,
    output logic            trap,
    input  logic            trap_clear
`endif
);

    dec_entry_t w_dec;
    dec_entry_t r_head;
    dec_entry_t r_tail;
    dec_entry_t w_head_nxt;
    dec_entry_t w_tail_nxt;
    logic [1:0] r_count;
    logic [1:0] w_count_nxt;
    logic       w_push;
    logic       w_pop;
    logic       w_stall;

    logic_dec_table u_table (
        .i_instr (in_instr),
        .o_entry (w_dec)
    );

    // in_ready looks only at registered state so the consumer never gates the producer.
    assign in_ready  = (r_count < 2'd2) && !w_stall;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

`ifdef LOGIC_DEC_TRAP_EN
    logic r_trap;
    logic w_trap_nxt;

    // Set on an illegal push takes priority over a coincident clear.
    always_comb begin
        w_trap_nxt = r_trap;
        if (w_push && w_dec.illegal) begin
            w_trap_nxt = 1'b1;
        end else if (trap_clear) begin
            w_trap_nxt = 1'b0;
        end else begin
            w_trap_nxt = r_trap;
        end
    end

    // Trap state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_trap_nxt;
        end
    end

    assign trap    = r_trap;
    assign w_stall = r_trap;
`else
    assign w_stall = 1'b0;
`endif

    // FIFO next-state: head is the oldest entry, tail is only meaningful at count 2.
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_count)
            2'd0: begin
                if (w_push) begin
                    w_head_nxt  = w_dec;
                    w_count_nxt = 2'd1;
                end else begin
                    w_count_nxt = 2'd0;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    w_head_nxt  = w_dec;
                end else if (w_push) begin
                    w_tail_nxt  = w_dec;
                    w_count_nxt = 2'd2;
                end else if (w_pop) begin
                    w_head_nxt  = '0;
                    w_count_nxt = 2'd0;
                end else begin
                    w_count_nxt = 2'd1;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    w_head_nxt  = r_tail;
                    w_tail_nxt  = '0;
                    w_count_nxt = 2'd1;
                end else begin
                    w_count_nxt = 2'd2;
                end
            end
            default: begin
                w_head_nxt  = '0;
                w_tail_nxt  = '0;
                w_count_nxt = 2'd0;
            end
        endcase
    end

    // FIFO storage and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    assign out_control = r_head.control;
    assign out_rs      = r_head.rs;
    assign out_rt      = r_head.rt;
    assign out_dest    = r_head.dest;
    assign out_use_imm = r_head.use_imm;
    assign out_imm     = {{(XLEN-16){1'b0}}, r_head.imm};
    assign out_illegal = r_head.illegal;

endmodule

// File: tb/tb_logic_op_decoder.sv
// Randomised self-checking bench for logic_op_decoder against a queue-based reference model.
module tb_logic_op_decoder;

`ifdef LOGIC_DEC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_control;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_dest;
    logic        out_use_imm;
    logic [31:0] out_imm;
    logic        out_illegal;
`ifdef LOGIC_DEC_TRAP_EN
    logic        trap;
    logic        trap_clear;
`endif

    always #5 clock = ~clock;

    logic_op_decoder #(.XLEN(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_control (out_control),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_dest    (out_dest),
        .out_use_imm (out_use_imm),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
`ifdef LOGIC_DEC_TRAP_EN
        ,
        .trap        (trap),
        .trap_clear  (trap_clear)
`endif
    );

    typedef struct packed {
        logic [1:0]  ctl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        use_imm;
        logic [31:0] imm;
        logic        illegal;
    } ref_t;

    ref_t m_q[$];
    bit   m_trap;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] I_AND = 32'h00851024;
    localparam logic [31:0] I_ORI = 32'h3483FFFF;
    localparam logic [31:0] I_NOR = 32'h00851027;
    localparam logic [31:0] I_XOR = 32'h00851026;
    localparam logic [31:0] I_LW  = 32'h8C000000;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Decoding rules straight from the instruction-field definitions.
    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t        r;
        int unsigned u, op, fn, sh, rs, rt, rd;
        u  = w;
        op = u >> 26;
        rs = (u >> 21) % 32;
        rt = (u >> 16) % 32;
        rd = (u >> 11) % 32;
        sh = (u >> 6) % 32;
        fn = u % 64;
        r = '0;
        r.illegal = 1'b1;
        if (op == 0 && sh == 0 && fn >= 36 && fn <= 39) begin
            r.illegal = 1'b0;
            r.rs      = rs[4:0];
            r.rt      = rt[4:0];
            r.dest    = rd[4:0];
            r.ctl     = (fn == 36) ? 2'd0 : (fn == 37) ? 2'd1 : (fn == 39) ? 2'd2 : 2'd3;
        end else if (op >= 12 && op <= 14) begin
            r.illegal = 1'b0;
            r.rs      = rs[4:0];
            r.dest    = rt[4:0];
            r.use_imm = 1'b1;
            r.imm     = u % 65536;
            r.ctl     = (op == 12) ? 2'd0 : (op == 13) ? 2'd1 : 2'd3;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        int unsigned k, rs, rt, rd, sh, fn, op;
        k  = $urandom_range(0, 3);
        rs = $urandom_range(0, 31);
        rt = $urandom_range(0, 31);
        rd = $urandom_range(0, 31);
        sh = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : 0;
        fn = 36 + $urandom_range(0, 3);
        op = 12 + $urandom_range(0, 2);
        case (k)
            0: return (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
            1: return (op << 26) | (rs << 21) | (rt << 16) | $urandom_range(0, 65535);
            2: return (rs << 21) | (rt << 16) | (rd << 11) | $urandom_range(0, 63);
            default: return $urandom;
        endcase
    endfunction

    task automatic check_outputs();
        ref_t h;
        check_val("in_ready", in_ready, (m_q.size() < 2) && !m_trap);
        check_val("out_valid", out_valid, m_q.size() > 0);
`ifdef LOGIC_DEC_TRAP_EN
        check_val("trap", trap, m_trap);
`endif
        if (m_q.size() > 0) begin
            h = m_q[0];
            check_val("control", out_control, h.ctl);
            check_val("rs", out_rs, h.rs);
            check_val("rt", out_rt, h.rt);
            check_val("dest", out_dest, h.dest);
            check_val("use_imm", out_use_imm, h.use_imm);
            check_val("imm", out_imm, h.imm);
            check_val("illegal", out_illegal, h.illegal);
        end
    endtask

    // One cycle: check at the falling edge, drive inputs, advance the model across the next rising edge.
    task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic clr);
        bit   exp_ready, push, pop;
        ref_t d;
        @(negedge clock);
        check_outputs();
        in_valid  = v;
        in_instr  = w;
        out_ready = rdy;
`ifdef LOGIC_DEC_TRAP_EN
        trap_clear = clr;
`endif
        d         = ref_decode(w);
        exp_ready = (m_q.size() < 2) && !m_trap;
        push      = v && exp_ready;
        pop       = (m_q.size() > 0) && rdy;
        if (TRAP_EN && push && d.illegal) m_trap = 1'b1;
        else if (TRAP_EN && clr) m_trap = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(d);
    endtask

    task automatic expect_head(input string tag, input logic [1:0] ctl, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] dest, input logic ui,
                               input logic [31:0] imm, input logic ill);
        check_val({tag, "_valid"}, out_valid, 1'b1);
        check_val({tag, "_ctl"}, out_control, ctl);
        check_val({tag, "_rs"}, out_rs, rs);
        check_val({tag, "_rt"}, out_rt, rt);
        check_val({tag, "_dest"}, out_dest, dest);
        check_val({tag, "_useimm"}, out_use_imm, ui);
        check_val({tag, "_imm"}, out_imm, imm);
        check_val({tag, "_illegal"}, out_illegal, ill);
    endtask

    // Reset with a word offered throughout; nothing may be accepted.
    task automatic do_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_instr = I_AND;
        m_q.delete();
        m_trap = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_val("rst_valid", out_valid, 1'b0);
            check_val("rst_fields", {out_control, out_rs, out_rt, out_dest, out_use_imm, out_illegal}, '0);
            check_val("rst_imm", out_imm, 32'd0);
`ifdef LOGIC_DEC_TRAP_EN
            check_val("rst_trap", trap, 1'b0);
`endif
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        check_val("rel_in_ready", in_ready, 1'b1);
        check_val("rel_valid", out_valid, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_AND;
        out_ready = 1'b0;
`ifdef LOGIC_DEC_TRAP_EN
        trap_clear = 1'b0;
`endif
        m_trap = 1'b0;
        do_reset();

        step(1'b1, I_AND, 1'b1, 1'b0);
        step(1'b1, I_ORI, 1'b1, 1'b0);
        expect_head("and", 2'b00, 5'd4, 5'd5, 5'd2, 1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        expect_head("ori", 2'b01, 5'd4, 5'd0, 5'd3, 1'b1, 32'h0000FFFF, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        step(1'b1, I_NOR, 1'b0, 1'b0);
        step(1'b1, I_XOR, 1'b0, 1'b0);
        step(1'b1, I_AND, 1'b0, 1'b0);
        check_val("full_in_ready", in_ready, 1'b0);
        expect_head("nor_hold", 2'b10, 5'd4, 5'd5, 5'd2, 1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        expect_head("nor", 2'b10, 5'd4, 5'd5, 5'd2, 1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        expect_head("xor", 2'b11, 5'd4, 5'd5, 5'd2, 1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);

        step(1'b1, I_LW, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        expect_head("lw", 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1);
`ifdef LOGIC_DEC_TRAP_EN
        check_val("lw_trap", trap, 1'b1);
        check_val("lw_in_ready", in_ready, 1'b0);
`endif
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0);
        end
        step(1'b0, 32'd0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
